// File: rtl/branch_pkg.sv
// Shared decode constants and helpers for the decode-stage branch predictor.
package branch_pkg;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Weakly not-taken: just below the taken/not-taken midpoint.
    function automatic int unsigned cnt_reset(input int unsigned width);
        return (32'd1 << (width - 1)) - 32'd1;
    endfunction

    function automatic int unsigned cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

    function automatic logic [31:0] imm_i(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[31:20]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] inst);
        return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] inst);
        return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/sat_counter_table.sv
// Table of saturating counters: one async read port, one saturating update port.
module sat_counter_table
    import branch_pkg::*;
#(
    parameter int unsigned DEPTH     = 64,
    parameter int unsigned CNT_WIDTH = 2,
    parameter int unsigned IDX_W     = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IDX_W-1:0]     rd_index,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    input  logic                 wr_en,
    input  logic [IDX_W-1:0]     wr_index,
    input  logic                 wr_inc
);

    localparam logic [CNT_WIDTH-1:0] CNT_RST = CNT_WIDTH'(cnt_reset(CNT_WIDTH));
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));

    logic [CNT_WIDTH-1:0] cnt_q [DEPTH];
    logic [CNT_WIDTH-1:0] wr_cur;
    logic [CNT_WIDTH-1:0] wr_next;

    // Lookup sees the pre-update value; no write-to-read bypass.
    assign rd_cnt = cnt_q[rd_index];
    assign wr_cur = cnt_q[wr_index];

    // Saturating step toward the resolved outcome.
    always_comb begin
        wr_next = wr_cur;
        if (wr_inc && (wr_cur != CNT_MAX)) begin
            wr_next = wr_cur + CNT_WIDTH'(1);
        end else if (!wr_inc && (wr_cur != '0)) begin
            wr_next = wr_cur - CNT_WIDTH'(1);
        end
    end

    // Counter storage, cleared to weakly not-taken on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt_q[i] <= CNT_RST;
            end
        end else if (wr_en) begin
            cnt_q[wr_index] <= wr_next;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Decode-stage branch resolver: decodes jumps/branches, computes targets and
// predicts conditional branches from a bimodal or gshare-indexed counter table.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int unsigned INST_WIDTH      = 32,
    parameter int unsigned INST_ADDR_WIDTH = 32,
    parameter int unsigned REGISTER_WIDTH  = 32,
    parameter int unsigned BHT_DEPTH       = 64,
    parameter int unsigned CNT_WIDTH       = 2,
    parameter bit          USE_GSHARE      = 1'b1,
    localparam int unsigned IDX_W          = $clog2(BHT_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [INST_WIDTH-1:0]      inst_IF_ID,
    input  logic [INST_ADDR_WIDTH-1:0] PC_IF_ID,
    input  logic [REGISTER_WIDTH-1:0]  rs1_data,
    output logic                       branch_taken,
    output logic                       branch_source,
    output logic [INST_ADDR_WIDTH-1:0] branch_jalr_target,
    output logic [INST_ADDR_WIDTH-1:0] branch_jal_beq_bne_target,
    output logic [IDX_W-1:0]           pred_index,
    output logic [IDX_W-1:0]           pred_ghr,
    input  logic                       upd_valid,
    input  logic [IDX_W-1:0]           upd_index,
    input  logic                       upd_taken,
    input  logic                       upd_mispredict,
    input  logic [IDX_W-1:0]           upd_ghr
);

    logic [6:0]                 opcode;
    logic                       is_cond;
    logic [IDX_W-1:0]           ghr_q;
    logic [IDX_W-1:0]           ghr_d;
    logic [IDX_W-1:0]           lookup_idx;
    logic [CNT_WIDTH-1:0]       lookup_cnt;
    logic                       pred_taken;
    logic [INST_ADDR_WIDTH-1:0] jalr_sum;

    assign opcode     = inst_IF_ID[6:0];
    assign is_cond    = enable && (opcode == OP_BRANCH);
    assign lookup_idx = PC_IF_ID[IDX_W+1:2] ^ (USE_GSHARE ? ghr_q : '0);
    assign pred_taken = lookup_cnt[CNT_WIDTH-1];
    assign jalr_sum   = INST_ADDR_WIDTH'(rs1_data)
                      + INST_ADDR_WIDTH'(signed'(imm_i(inst_IF_ID[31:0])));

    sat_counter_table #(
        .DEPTH     (BHT_DEPTH),
        .CNT_WIDTH (CNT_WIDTH),
        .IDX_W     (IDX_W)
    ) u_table (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_index (lookup_idx),
        .rd_cnt   (lookup_cnt),
        .wr_en    (upd_valid),
        .wr_index (upd_index),
        .wr_inc   (upd_taken)
    );

    // Redirect decision and targets; every output is zero unless its class matches.
    always_comb begin
        branch_taken              = 1'b0;
        branch_source             = 1'b0;
        branch_jalr_target        = '0;
        branch_jal_beq_bne_target = '0;
        pred_index                = '0;
        pred_ghr                  = '0;
        if (enable) begin
            unique case (opcode)
                OP_JAL: begin
                    branch_taken              = 1'b1;
                    branch_jal_beq_bne_target = PC_IF_ID
                        + INST_ADDR_WIDTH'(signed'(imm_j(inst_IF_ID[31:0])));
                end
                OP_JALR: begin
                    branch_taken       = 1'b1;
                    branch_source      = 1'b1;
                    branch_jalr_target = {jalr_sum[INST_ADDR_WIDTH-1:1], 1'b0};
                end
                OP_BRANCH: begin
                    branch_taken              = pred_taken;
                    branch_jal_beq_bne_target = PC_IF_ID
                        + INST_ADDR_WIDTH'(signed'(imm_b(inst_IF_ID[31:0])));
                    pred_index                = lookup_idx;
                    pred_ghr                  = ghr_q;
                end
                default: ;
            endcase
        end
    end

    // History next-state: EX repair overrides the speculative shift.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid && upd_mispredict) begin
            ghr_d = IDX_W'({upd_ghr, upd_taken});
        end else if (is_cond) begin
            ghr_d = IDX_W'({ghr_q, pred_taken});
        end
    end

    // Global history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor (default parameters, gshare indexing).
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] inst = 32'h0000_0013;
    logic [31:0] pc = '0;
    logic [31:0] rs1 = '0;
    logic        upd_valid = 1'b0;
    logic [5:0]  upd_index = '0;
    logic        upd_taken = 1'b0;
    logic        upd_mispredict = 1'b0;
    logic [5:0]  upd_ghr = '0;

    logic        branch_taken;
    logic        branch_source;
    logic [31:0] branch_jalr_target;
    logic [31:0] branch_jal_beq_bne_target;
    logic [5:0]  pred_index;
    logic [5:0]  pred_ghr;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        taken;
        logic        src;
        logic [31:0] jalr_t;
        logic [31:0] jal_t;
        logic [5:0]  idx;
        logic [5:0]  ghr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          m_cnt[64];
    logic [5:0]  m_ghr;
    logic [31:0] cur_imm;

    always #5 clk = ~clk;

    branch_predictor dut (
        .clk                       (clk),
        .rst_n                     (rst_n),
        .enable                    (enable),
        .inst_IF_ID                (inst),
        .PC_IF_ID                  (pc),
        .rs1_data                  (rs1),
        .branch_taken              (branch_taken),
        .branch_source             (branch_source),
        .branch_jalr_target        (branch_jalr_target),
        .branch_jal_beq_bne_target (branch_jal_beq_bne_target),
        .pred_index                (pred_index),
        .pred_ghr                  (pred_ghr),
        .upd_valid                 (upd_valid),
        .upd_index                 (upd_index),
        .upd_taken                 (upd_taken),
        .upd_mispredict            (upd_mispredict),
        .upd_ghr                   (upd_ghr)
    );

    function automatic logic [31:0] enc_j(input logic [31:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6F};
    endfunction

    function automatic logic [31:0] enc_jalr(input logic [31:0] imm);
        return {imm[11:0], 5'd1, 3'b000, 5'd0, 7'h67};
    endfunction

    function automatic logic [31:0] enc_b(input logic [31:0] imm);
        return {imm[12], imm[10:5], 5'd2, 5'd1, 3'b000, imm[4:1], imm[11], 7'h63};
    endfunction

    // Reference outputs from the bench's own counter/history model and known immediate.
    function automatic exp_t model_out();
        exp_t       r;
        logic [5:0] i;
        r = '0;
        if (enable) begin
            case (inst[6:0])
                7'h6F: begin
                    r.taken = 1'b1;
                    r.jal_t = pc + cur_imm;
                end
                7'h67: begin
                    r.taken  = 1'b1;
                    r.src    = 1'b1;
                    r.jalr_t = (rs1 + cur_imm) & 32'hFFFF_FFFE;
                end
                7'h63: begin
                    i       = pc[7:2] ^ m_ghr;
                    r.taken = (m_cnt[i] >= 2);
                    r.jal_t = pc + cur_imm;
                    r.idx   = i;
                    r.ghr   = m_ghr;
                end
                default: ;
            endcase
        end
        return r;
    endfunction

    function automatic exp_t obs();
        return {branch_taken, branch_source, branch_jalr_target, branch_jal_beq_bne_target,
                pred_index, pred_ghr};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_cnt[i] = 1;
        m_ghr = '0;
    endtask

    // Advance the model by one rising edge using the currently held inputs.
    task automatic model_clock();
        logic [5:0] nghr;
        logic [5:0] i;
        nghr = m_ghr;
        if (enable && inst[6:0] == 7'h63) begin
            i    = pc[7:2] ^ m_ghr;
            nghr = {m_ghr[4:0], m_cnt[i] >= 2};
        end
        if (upd_valid && upd_mispredict) nghr = {upd_ghr[4:0], upd_taken};
        if (upd_valid) begin
            if (upd_taken && m_cnt[upd_index] < 3) m_cnt[upd_index]++;
            if (!upd_taken && m_cnt[upd_index] > 0) m_cnt[upd_index]--;
        end
        m_ghr = nghr;
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        @(negedge clk);
    endtask

    task automatic expect_now();
        exp_q.push_back(model_out());
    endtask

    task automatic no_upd();
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        upd_taken      = 1'b0;
        upd_index      = '0;
        upd_ghr        = '0;
    endtask

    task automatic set_upd(input logic [5:0] idx, input logic tk);
        upd_valid      = 1'b1;
        upd_index      = idx;
        upd_taken      = tk;
        upd_mispredict = 1'b0;
        upd_ghr        = '0;
    endtask

    task automatic drive_beq(input logic [31:0] p, input logic [31:0] imm);
        inst    = enc_b(imm);
        pc      = p;
        cur_imm = imm;
        rs1     = $urandom;
    endtask

    // Conditional branch whose PC makes the lookup land on table entry idx.
    task automatic drive_cond_idx(input logic [5:0] idx);
        logic [5:0] t;
        t = idx ^ m_ghr;
        drive_beq(32'h0000_4000 | {24'd0, t, 2'b00}, 32'h0000_0010);
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        model_reset();
        no_upd();
        drive_beq(32'h0000_0100, 32'hFFFF_FFF8);
        expect_now();
        #3;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL reset_beq got=%h want=%h", obs(), e);
        end
        checks++;
        if (branch_jal_beq_bne_target !== 32'h0000_00F8) begin
            failures++;
            $display("FAIL reset_beq_target got=%h want=000000f8", branch_jal_beq_bne_target);
        end
        checks++;
        if (branch_taken !== 1'b0 || pred_index !== 6'd0 || pred_ghr !== 6'd0) begin
            failures++;
            $display("FAIL reset_beq_pred got=%b/%h/%h want=0/00/00",
                     branch_taken, pred_index, pred_ghr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_other_and_enable();
        // Non-branch opcode, then enable low while EX keeps training entry 9.
        inst = 32'h0000_0013;
        pc   = 32'h0000_0300;
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || branch_taken !== 1'b0) begin
            failures++;
            $display("FAIL non_branch got=%h want=%h", obs(), e);
        end
        step();
        enable = 1'b0;
        for (int k = 0; k < 2; k++) begin
            drive_cond_idx(6'd9);
            set_upd(6'd9, 1'b1);
            expect_now();
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e || obs() !== '0) begin
                failures++;
                $display("FAIL enable_low got=%h want=%h", obs(), e);
            end
            step();
        end
        enable = 1'b1;
        no_upd();
        drive_cond_idx(6'd9);
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || branch_taken !== 1'b1) begin
            failures++;
            $display("FAIL update_while_disabled got=%h want=%h", obs(), e);
        end
        step();
    endtask

    task automatic test_jumps();
        inst    = enc_j(32'h0000_0040);
        cur_imm = 32'h0000_0040;
        pc      = 32'h0000_0200;
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL jal got=%h want=%h", obs(), e);
        end
        checks++;
        if (branch_taken !== 1'b1 || branch_source !== 1'b0
            || branch_jal_beq_bne_target !== 32'h0000_0240) begin
            failures++;
            $display("FAIL jal_const got=%b/%b/%h want=1/0/00000240",
                     branch_taken, branch_source, branch_jal_beq_bne_target);
        end
        step();
        inst    = enc_jalr(32'h0000_0004);
        cur_imm = 32'h0000_0004;
        rs1     = 32'h0000_1003;
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL jalr got=%h want=%h", obs(), e);
        end
        checks++;
        if (branch_taken !== 1'b1 || branch_source !== 1'b1
            || branch_jalr_target !== 32'h0000_1006 || branch_jal_beq_bne_target !== '0) begin
            failures++;
            $display("FAIL jalr_const got=%b/%b/%h want=1/1/00001006",
                     branch_taken, branch_source, branch_jalr_target);
        end
        step();
    endtask

    task automatic test_saturation();
        // Lookup entry 5 every cycle while EX pushes it up, down, and back up.
        logic pattern [11] = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1};
        for (int k = 0; k < 11; k++) begin
            drive_cond_idx(6'd5);
            set_upd(6'd5, pattern[k]);
            expect_now();
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e) begin
                failures++;
                $display("FAIL saturation_%0d got=%h want=%h", k, obs(), e);
            end
            if (k == 2) begin
                checks++;
                if (branch_taken !== 1'b1) begin
                    failures++;
                    $display("FAIL trained_taken got=%b want=1", branch_taken);
                end
            end
            step();
        end
        no_upd();
    endtask

    task automatic test_same_index();
        drive_cond_idx(6'd20);
        set_upd(6'd20, 1'b1);
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || branch_taken !== 1'b0) begin
            failures++;
            $display("FAIL same_idx_old got=%h want=%h", obs(), e);
        end
        step();
        no_upd();
        drive_cond_idx(6'd20);
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || branch_taken !== 1'b1) begin
            failures++;
            $display("FAIL same_idx_new got=%h want=%h", obs(), e);
        end
        step();
    endtask

    task automatic test_reset_mid();
        drive_cond_idx(6'd5);
        set_upd(6'd5, 1'b1);
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || branch_taken !== 1'b1) begin
            failures++;
            $display("FAIL pre_reset got=%h want=%h", obs(), e);
        end
        #1;
        rst_n = 1'b0;
        model_reset();
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || branch_taken !== 1'b0 || pred_ghr !== 6'd0) begin
            failures++;
            $display("FAIL async_reset got=%h want=%h", obs(), e);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        no_upd();
        drive_cond_idx(6'd9);
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e || branch_taken !== 1'b0) begin
            failures++;
            $display("FAIL post_reset_idx9 got=%h want=%h", obs(), e);
        end
        step();
    endtask

    task automatic test_gshare_repair();
        logic [5:0] ids [4] = '{6'd1, 6'd2, 6'd3, 6'd4};
        for (int k = 0; k < 4; k++) begin
            drive_cond_idx(ids[k]);
            if (k == 3) begin
                upd_valid      = 1'b1;
                upd_index      = 6'd10;
                upd_taken      = 1'b1;
                upd_mispredict = 1'b1;
                upd_ghr        = 6'b000101;
            end else begin
                no_upd();
            end
            expect_now();
            #1;
            e = exp_q.pop_front();
            checks++;
            if (obs() !== e || branch_taken !== 1'b0) begin
                failures++;
                $display("FAIL gshare_pred_%0d got=%h want=%h", k, obs(), e);
            end
            step();
        end
        no_upd();
        drive_cond_idx(6'd30);
        expect_now();
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs() !== e) begin
            failures++;
            $display("FAIL gshare_after got=%h want=%h", obs(), e);
        end
        checks++;
        if (pred_ghr !== 6'b001011) begin
            failures++;
            $display("FAIL repair_wins got=%b want=001011", pred_ghr);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_other_and_enable();
        test_jumps();
        test_saturation();
        test_same_index();
        test_reset_mid();
        test_gshare_repair();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
